// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands load in parallel on start, one bit per clock LSB first,
// registered parallel result with a one-cycle done pulse. Full-adder slice built from two Half_Adder cells.

module Half_Adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;

    logic p, g0, s_bit, g1, c_nxt;

    // full-adder slice: propagate/generate from the operand bits, then fold in the carry
    Half_Adder u_ha0 (.a(a_sr[0]), .b(b_sr[0]), .s(p),     .c(g0));
    Half_Adder u_ha1 (.a(p),       .b(carry),   .s(s_bit), .c(g1));
    assign c_nxt = g0 | g1;

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // sum/cout are only written on the final bit so no partial result is ever visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sr  <= a;
                    b_sr  <= b;
                    carry <= cin;
                    cnt   <= '0;
                end
                RUN: begin
                    s_sr  <= {s_bit, s_sr[WIDTH-1:1]};
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= c_nxt;
                    if (last) begin
                        sum  <= {s_bit, s_sr[WIDTH-1:1]};
                        cout <= c_nxt;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
